// File: rtl/hazard_control_pkg.sv
// Shared encodings, default latencies and pipeline shadow types for hazard control.
package hazard_control_pkg;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_EXM  = 2'b10;
  localparam logic [1:0] FW_WB   = 2'b01;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;

  // Register-level view of the instruction sitting in execute
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } e_shadow_t;

  // Writer view of an instruction in memory or writeback
  typedef struct packed {
    logic [4:0] dest;
    logic       reg_write;
  } wr_shadow_t;

  // Forward select for one source: the younger (M) writer wins over W; $0 never forwards
  function automatic logic [1:0] fw_sel(input logic [4:0] src,
                                        input wr_shadow_t m,
                                        input wr_shadow_t w);
    if (m.reg_write && m.dest != 5'd0 && m.dest == src) return FW_EXM;
    if (w.reg_write && w.dest != 5'd0 && w.dest == src) return FW_WB;
    return FW_NONE;
  endfunction

endpackage

// File: rtl/hazard_control_md_sequencer.sv
// Multiply/divide busy countdown: loads the op latency on start, counts to zero.
module md_sequencer
  import hazard_control_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [5:0] count;

  // A start while busy is dropped; busy always takes priority so the count never reloads mid-op
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= 6'd0;
    else if (count != 6'd0) count <= count - 6'd1;
    else if (start)         count <= is_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
  end

  // Done is the last busy cycle, so release and completion coincide
  always_comb begin
    busy = (count != 6'd0);
    done = (count == 6'd1);
  end

endmodule

// File: rtl/hazard_control.sv
// Forwarding selects, load-use interlock and mult/div stall for a 5-stage pipeline.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_addrD,
  input  logic [4:0] rt_addrD,
  input  logic       uses_rsD,
  input  logic       uses_rtD,
  input  logic [4:0] write_reg_addrD,
  input  logic       reg_writeD,
  input  logic       mem_readD,
  input  logic       md_startE,
  input  logic       md_is_divE,
  output logic [1:0] fw_alu1,
  output logic [1:0] fw_alu2,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       md_busy,
  output logic       md_done
);

  e_shadow_t  e_q;
  wr_shadow_t m_q, w_q;
  logic       load_use;

  md_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (md_startE),
    .is_div(md_is_divE),
    .busy  (md_busy),
    .done  (md_done)
  );

  // Load-use is masked during a mult/div stall and re-evaluated once the unit releases
  always_comb begin
    load_use = e_q.mem_read && e_q.dest != 5'd0 &&
               ((uses_rsD && rs_addrD == e_q.dest) ||
                (uses_rtD && rt_addrD == e_q.dest)) &&
               !md_busy;
    stallF   = md_busy | load_use;
    stallD   = md_busy | load_use;
    stallE   = md_busy;
    flushE   = load_use;
    fw_alu1  = fw_sel(e_q.rs, m_q, w_q);
    fw_alu2  = fw_sel(e_q.rt, m_q, w_q);
  end

  // Execute shadow: flush beats hold beats advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       e_q <= '0;
    else if (flushE) e_q <= '0;
    else if (!stallE)
      e_q <= '{rs: rs_addrD, rt: rt_addrD, dest: write_reg_addrD,
               reg_write: reg_writeD, mem_read: mem_readD};
  end

  // Memory/writeback shadows: a held execute stage feeds a bubble downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= stallE ? '0 : '{dest: e_q.dest, reg_write: e_q.reg_write};
      w_q <= m_q;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Scripted pipeline scenarios; each cycle's expected outputs are queued and checked at negedge.
module tb_hazard_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_addrD, rt_addrD, write_reg_addrD;
  logic       uses_rsD, uses_rtD, reg_writeD, mem_readD, md_startE, md_is_divE;
  logic [1:0] fw_alu1, fw_alu2;
  logic       stallF, stallD, stallE, flushE, md_busy, md_done;

  typedef struct packed {
    logic [4:0] rs, rt, wr;
    logic       urs, urt, rw, mr;
  } d_t;

  typedef struct {
    string      tag;
    logic [9:0] e;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  hazard_control #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .rs_addrD(rs_addrD), .rt_addrD(rt_addrD),
    .uses_rsD(uses_rsD), .uses_rtD(uses_rtD),
    .write_reg_addrD(write_reg_addrD), .reg_writeD(reg_writeD), .mem_readD(mem_readD),
    .md_startE(md_startE), .md_is_divE(md_is_divE),
    .fw_alu1(fw_alu1), .fw_alu2(fw_alu2),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
    .md_busy(md_busy), .md_done(md_done)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b (fw1 fw2 sF sD sE fE busy done)", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ex(input logic [1:0] f1, input logic [1:0] f2,
                                    input logic sf, input logic sd, input logic se,
                                    input logic fe, input logic b, input logic d);
    return {f1, f2, sf, sd, se, fe, b, d};
  endfunction

  function automatic d_t nop();
    return '0;
  endfunction

  function automatic d_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return '{rs: rs, rt: rt, wr: rd, urs: 1'b1, urt: 1'b1, rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic d_t lw(input logic [4:0] rt, input logic [4:0] base);
    return '{rs: base, rt: rt, wr: rt, urs: 1'b1, urt: 1'b0, rw: 1'b1, mr: 1'b1};
  endfunction

  // Drive one cycle of decode/execute inputs and queue what the outputs must be this cycle
  task automatic cyc(input d_t d, input logic ms, input logic md, input logic rst_v,
                     input logic [9:0] e, input string tag);
    sb_t it;
    @(posedge clk); #1;
    reset           = rst_v;
    rs_addrD        = d.rs;
    rt_addrD        = d.rt;
    uses_rsD        = d.urs;
    uses_rtD        = d.urt;
    write_reg_addrD = d.wr;
    reg_writeD      = d.rw;
    mem_readD       = d.mr;
    md_startE       = ms;
    md_is_divE      = md;
    it.tag = tag;
    it.e   = e;
    sb.push_back(it);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(nop(), 1'b0, 1'b0, 1'b0, 10'd0, "idle");
  endtask

  // Scoreboard consumer: compare the oldest expectation against the live outputs
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t it;
      it = sb.pop_front();
      chk(it.tag, {fw_alu1, fw_alu2, stallF, stallD, stallE, flushE, md_busy, md_done}, it.e);
    end
  end

  initial begin
    logic [9:0] E0, BUSY, BUSYD, LU;
    E0    = 10'd0;
    BUSY  = ex(2'b00, 2'b00, 1, 1, 1, 0, 1, 0);
    BUSYD = ex(2'b00, 2'b00, 1, 1, 1, 0, 1, 1);
    LU    = ex(2'b00, 2'b00, 1, 1, 0, 1, 0, 0);

    reset = 1'b1;
    {rs_addrD, rt_addrD, write_reg_addrD} = '0;
    {uses_rsD, uses_rtD, reg_writeD, mem_readD, md_startE, md_is_divE} = '0;

    cyc(nop(), 0, 0, 1, E0, "rst_hold");
    cyc(nop(), 0, 0, 0, E0, "rst_rel");
    idle(2);

    // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A
    cyc(alu(3, 1, 2), 0, 0, 0, E0, "b2b_add");
    cyc(alu(4, 3, 5), 0, 0, 0, E0, "b2b_sub_d");
    cyc(nop(),        0, 0, 0, ex(2'b10, 2'b00, 0, 0, 0, 0, 0, 0), "b2b_fw1_exm");
    idle(3);

    // writer two ahead of an rt reader -> WB forward on B
    cyc(alu(3, 1, 2), 0, 0, 0, E0, "wb_add");
    cyc(nop(),        0, 0, 0, E0, "wb_gap");
    cyc(alu(8, 9, 3), 0, 0, 0, E0, "wb_rd_d");
    cyc(nop(),        0, 0, 0, ex(2'b00, 2'b01, 0, 0, 0, 0, 0, 0), "wb_fw2_wb");
    idle(3);

    // $3 written in both M and W -> M wins
    cyc(alu(3, 1, 2), 0, 0, 0, E0, "pri_add1");
    cyc(alu(3, 4, 5), 0, 0, 0, E0, "pri_add2");
    cyc(alu(8, 9, 3), 0, 0, 0, E0, "pri_rd_d");
    cyc(nop(),        0, 0, 0, ex(2'b00, 2'b10, 0, 0, 0, 0, 0, 0), "pri_fw2_exm");
    idle(3);

    // lw $6 ; add $7,$6,$1 -> one bubble, then WB forward on A
    cyc(lw(6, 1),     0, 0, 0, E0, "lu_lw");
    cyc(alu(7, 6, 1), 0, 0, 0, LU, "lu_stall");
    cyc(alu(7, 6, 1), 0, 0, 0, E0, "lu_bubble");
    cyc(nop(),        0, 0, 0, ex(2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "lu_fw1_wb");
    idle(3);

    // $0 writers (alu and load) never forward or stall
    cyc(alu(0, 1, 2), 0, 0, 0, E0, "z_add");
    cyc(alu(8, 0, 0), 0, 0, 0, E0, "z_rd_d");
    cyc(nop(),        0, 0, 0, E0, "z_rd_e");
    idle(2);
    cyc(lw(0, 1),     0, 0, 0, E0, "z_lw");
    cyc(alu(9, 0, 0), 0, 0, 0, E0, "z_lw_nostall");
    cyc(nop(),        0, 0, 0, E0, "z_lw_rd_e");
    cyc(nop(),        0, 0, 0, E0, "z_lw_w");
    idle(2);

    // mult with a load-use pending: masked while busy, taken after release
    cyc(lw(6, 1), 1, 0, 0, E0, "mul_start");
    for (int i = 1; i <= 4; i++)
      cyc(alu(7, 6, 1), 0, 0, 0, (i == 4) ? BUSYD : BUSY, "mul_busy");
    cyc(alu(7, 6, 1), 0, 0, 0, LU, "mul_lu_after");
    cyc(alu(7, 6, 1), 0, 0, 0, E0, "mul_bubble");
    cyc(nop(),        0, 0, 0, ex(2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "mul_fw1_wb");
    idle(3);

    // divide: 32 busy cycles, done on the last, restart mid-op ignored
    cyc(nop(), 1, 1, 0, E0, "div_start");
    for (int i = 1; i <= 32; i++)
      cyc(nop(), (i == 5), 1'b0, 0, (i == 32) ? BUSYD : BUSY, "div_busy");
    cyc(nop(), 0, 0, 0, E0, "div_end");
    idle(6);

    // reset at divide cycle 10 clears busy at once and never produces done
    cyc(nop(), 1, 1, 0, E0, "rd_start");
    for (int i = 1; i <= 9; i++) cyc(nop(), 0, 0, 0, BUSY, "rd_busy");
    cyc(nop(), 0, 0, 1, E0, "rd_reset");
    cyc(nop(), 0, 0, 0, E0, "rd_release");
    for (int i = 0; i < 30; i++) cyc(nop(), 0, 0, 0, E0, "rd_no_done");

    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) chk("sb_drain", 10'(sb.size()), 10'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, meaning multiply busy duration in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning divide busy duration in cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rs_addrD / rt_addrD  input  5 each  source register addresses of the decode-stage instruction.
REQ-006 SHALL have port uses_rsD / uses_rtD  input  1 each  decode instruction actually reads rs / rt.
REQ-007 SHALL have port write_reg_addrD  input  5  decode destination register, already rd/rt-selected.
REQ-008 SHALL have port reg_writeD / mem_readD  input  1 each  decode instruction writes a register / is a load.
REQ-009 SHALL have port md_startE  input  1  execute-stage instruction is mult/multu/div/divu.
REQ-010 SHALL have port md_is_divE  input  1  1 = divide, 0 = multiply; qualified by md_startE.
REQ-011 SHALL have port fw_alu1 / fw_alu2  output  2 each  ALU operand A / B forwarding selects: 00 none, 10 from alu_outM, 01 from write_resultW.
REQ-012 SHALL have port stallF / stallD / stallE  output  1 each  hold the fetch / decode / execute pipeline registers.
REQ-013 SHALL have port flushE  output  1  insert a bubble into the execute register.
REQ-014 SHALL have port md_busy / md_done  output  1 each  mult/div unit in progress / one-cycle completion pulse.

Function
REQ-015 SHALL keep internal shadow registers for E (rsE, rtE, destE, reg_writeE, mem_readE), M (destM, reg_writeM) and W (destW, reg_writeW).
REQ-016 E update SHALL follow this priority: flushE -> zero all E fields; else stallE -> hold; else load from the D inputs.
REQ-017 M update SHALL be: stallE -> bubble (reg_writeM=0, destM=0); else copy from E. W SHALL always copy from M.
REQ-018 fw_alu1 SHALL be 10 if reg_writeM & destM!=0 & destM==rsE; else 01 if reg_writeW & destW!=0 & destW==rsE; else 00. M SHALL win when both match.
REQ-019 fw_alu2 SHALL use the same rule as REQ-018 with rtE; both selects SHALL be combinational from the shadow state.
REQ-020 Load-use SHALL be detected when mem_readE & destE!=0 & ((uses_rsD & rs_addrD==destE) | (uses_rtD & rt_addrD==destE)).
REQ-021 On load-use (with md_busy=0), stallF=1, stallD=1 and flushE=1 for exactly one cycle; the following cycle forwards via 10 or 01.
REQ-022 Register $0 SHALL never cause forwarding or a stall.
REQ-023 The mult/div counter SHALL be 6 bits and reset to 0; md_busy = (count != 0).
REQ-024 With md_busy=0 and md_startE=1, the counter SHALL load DIV_CYCLES if md_is_divE, else MULT_CYCLES; md_startE SHALL be ignored while md_busy=1.
REQ-025 While md_busy=1, the counter SHALL decrement by 1 per cycle and stallF=stallD=stallE=1.
REQ-026 While md_busy=1, flushE SHALL be 0 and load-use SHALL be masked; it is re-evaluated after release.
REQ-027 md_done SHALL be 1 in the cycle the counter equals 1, and 0 at all other times.
REQ-028 The counter SHALL never wrap below 0.

Reset
REQ-029 Asserting reset SHALL immediately clear all shadow registers and the counter, in any cycle including mid-divide.
REQ-030 After reset, outputs SHALL be fw_alu1=fw_alu2=00, all stalls 0, flushE=0, md_busy=0 and md_done=0, with no stale stall carried over.

Structure
REQ-031 A shared package SHALL hold the FW_NONE=2'b00, FW_EXM=2'b10 and FW_WB=2'b01 encodings and the MULT_CYCLES/DIV_CYCLES defaults.
REQ-032 The mult/div countdown SHALL be a sub-module named md_sequencer (ports: start, is_div, busy, done, clk, reset).

Verification
REQ-033 Back-to-back add $3,$1,$2 then sub $4,$3,$5 -> fw_alu1=10 in the sub's E cycle, with no stall.
REQ-034 add $3 followed two instructions later by a reader of $3 in rt -> fw_alu2=01; with $3 also in M -> fw_alu2=10.
REQ-035 lw $6 then add $7,$6,$1 -> one cycle of stallF=stallD=flushE=1, then fw_alu1=01.
REQ-036 div with DIV_CYCLES=32 -> md_busy high 32 cycles; md_done at cycle 32; a second md_startE during busy is ignored.
REQ-037 Reset asserted at divide cycle 10 -> md_busy=0 and stalls 0 immediately, with no md_done.
REQ-038 Writes to $0 followed by a reader of $0 -> fw=00 and no stall, including when the writer is a load.
